// File: rtl/mu_mem_arbiter.sv
// mu_mem_arbiter: shares the instruction ROM and data RAM between the
// fetch port (IF, read-only) and the data port (D). Each granted request
// runs IDLE -> ACCESS -> WAIT -> RESP. The response pulse appears in the
// cycle after the RESP edge, so the request sampled at E0 is acknowledged
// in the cycle following E3, for both good and errored accesses.
module mu_mem_arbiter #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 64,
  parameter int          IDX_W      = 6,
  parameter logic [31:0] ROM_BASE   = 32'h0040_0000,
  parameter logic [31:0] RAM_BASE   = 32'h1001_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [31:0]           if_addr,
  output logic                  if_ack,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [31:0]           d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_err,
  output logic [IDX_W-1:0]      rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_rdata,
  output logic [IDX_W-1:0]      ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

  // Byte span covered by each memory (ADDR_WIDTH words of 4 bytes).
  localparam logic [31:0] SPAN = 32'(4 * ADDR_WIDTH);

  logic [1:0]            state;
  logic                  last_grant;
  logic                  owner;
  logic                  lat_we;
  logic                  lat_err;
  logic                  lat_rom;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;

  logic                  grant_any;
  logic                  grant_d;
  logic [31:0]           sel_addr;
  logic                  sel_we;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [31:0]           rom_off;
  logic [31:0]           ram_off;
  logic                  hit_rom;
  logic                  hit_ram;
  logic                  dec_err;
  logic [IDX_W-1:0]      dec_idx;

  assign busy = (state != ST_IDLE);

  // Pick the winner (alternating under contention) and decode its address.
  always_comb begin
    grant_any = if_req | d_req;
    grant_d   = d_req & (~if_req | (last_grant == GNT_IF));
    sel_addr  = grant_d ? d_addr : if_addr;
    sel_we    = grant_d & d_we;
    sel_wdata = grant_d ? d_wdata : '0;
    rom_off   = sel_addr - ROM_BASE;
    ram_off   = sel_addr - RAM_BASE;
    hit_rom   = (sel_addr >= ROM_BASE) && (rom_off < SPAN);
    hit_ram   = (sel_addr >= RAM_BASE) && (ram_off < SPAN);
    dec_err   = (sel_addr[1:0] != 2'b00) | ~(hit_rom | hit_ram) | (hit_rom & sel_we);
    dec_idx   = hit_rom ? rom_off[IDX_W+1:2] : ram_off[IDX_W+1:2];
  end

  // Sequence one access per grant and register every output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= GNT_D;
      owner      <= GNT_IF;
      lat_we     <= 1'b0;
      lat_err    <= 1'b0;
      lat_rom    <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      rom_addr   <= '0;
      ram_addr   <= '0;
      ram_we     <= 1'b0;
      ram_wdata  <= '0;
      if_ack     <= 1'b0;
      if_rdata   <= '0;
      if_err     <= 1'b0;
      d_ack      <= 1'b0;
      d_rdata    <= '0;
      d_err      <= 1'b0;
    end else begin
      ram_we   <= 1'b0;
      if_ack   <= 1'b0;
      if_rdata <= '0;
      if_err   <= 1'b0;
      d_ack    <= 1'b0;
      d_rdata  <= '0;
      d_err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            state      <= ST_ACCESS;
            owner      <= grant_d;
            last_grant <= grant_d;
            lat_we     <= sel_we;
            lat_err    <= dec_err;
            lat_rom    <= hit_rom;
            ram_wdata  <= sel_wdata;
            if (!dec_err) begin
              if (hit_rom) rom_addr <= dec_idx;
              else         ram_addr <= dec_idx;
            end
            ram_we <= ~dec_err & hit_ram & sel_we;
          end
        end
        ST_ACCESS: state <= ST_WAIT;
        ST_WAIT: begin
          state   <= ST_RESP;
          err_q   <= lat_err;
          rdata_q <= (lat_err | lat_we) ? '0 : (lat_rom ? rom_rdata : ram_rdata);
        end
        ST_RESP: begin
          state <= ST_IDLE;
          if (owner == GNT_D) begin
            d_ack   <= 1'b1;
            d_rdata <= rdata_q;
            d_err   <= err_q;
          end else begin
            if_ack   <= 1'b1;
            if_rdata <= rdata_q;
            if_err   <= err_q;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mu_mem_arbiter.sv
// tb_mu_mem_arbiter: directed vector table for single transactions plus
// hand-written sequences for contention and reset abort. Bench-side ROM
// and RAM models supply memory data with one-cycle read latency.
module tb_mu_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic [5:0]  rom_addr;
  logic [31:0] rom_rdata;
  logic [5:0]  ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        busy;

  int total = 0;
  int bad = 0;
  int we_cnt = 0;

  logic [31:0] ram_mem [64];

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_rom;
    logic        exp_ram;
    logic [5:0]  exp_idx;
  } vec_t;

  vec_t vecs [15];

  mu_mem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .if_err    (if_err),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .rom_addr  (rom_addr),
    .rom_rdata (rom_rdata),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // ROM model: word 2 holds a fixed instruction, others A000_00xx.
  always @(posedge clk)
    rom_rdata <= (rom_addr == 6'd2) ? 32'h2010_0005 : (32'hA000_0000 | {26'd0, rom_addr});

  // RAM model: synchronous read, write on ram_we, preloaded with 5000_00xx.
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  // Count every cycle the RAM write strobe is sampled high.
  always @(posedge clk)
    if (ram_we) we_cnt <= we_cnt + 1;

  // RAM preload.
  initial begin
    for (int i = 0; i < 64; i++) ram_mem[i] <= 32'h5000_0000 | i;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
    end
  endtask

  // Runs one transaction from a negedge and checks each stage at fixed latency.
  task automatic applyStimulus(input vec_t v, input string tag);
    int we_before;
    int exp_we;
    exp_we = (v.is_d && v.we && !v.exp_err) ? 1 : 0;
    if (v.is_d) begin
      d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    we_before = we_cnt;
    @(posedge clk); @(negedge clk);
    checkOutput({tag, " busy"}, busy, 1);
    if (v.exp_rom) checkOutput({tag, " rom_addr"}, rom_addr, v.exp_idx);
    if (v.exp_ram) checkOutput({tag, " ram_addr"}, ram_addr, v.exp_idx);
    checkOutput({tag, " ram_we"}, ram_we, exp_we);
    @(posedge clk); @(negedge clk);
    checkOutput({tag, " early ack1"}, {if_ack, d_ack}, 0);
    @(posedge clk); @(negedge clk);
    checkOutput({tag, " early ack2"}, {if_ack, d_ack}, 0);
    @(posedge clk); @(negedge clk);
    if (v.is_d) begin
      checkOutput({tag, " d_ack"}, {if_ack, d_ack}, 1);
      checkOutput({tag, " d_rdata"}, d_rdata, v.exp_rdata);
      checkOutput({tag, " d_err"}, d_err, v.exp_err);
      d_req = 1'b0;
    end else begin
      checkOutput({tag, " if_ack"}, {if_ack, d_ack}, 2);
      checkOutput({tag, " if_rdata"}, if_rdata, v.exp_rdata);
      checkOutput({tag, " if_err"}, if_err, v.exp_err);
      if_req = 1'b0;
    end
    checkOutput({tag, " busy idle"}, busy, 0);
    checkOutput({tag, " we count"}, we_cnt - we_before, exp_we);
  endtask

  initial begin
    int order [4];
    int n;
    int cycles;
    int lowrun;
    int maxlow;
    vec_t fresh;

    //           is_d  we    addr           wdata          rdata          err   rom   ram   idx
    vecs[0]  = '{1'b0, 1'b0, 32'h0040_0008, 32'h0,         32'h2010_0005, 1'b0, 1'b1, 1'b0, 6'd2};
    vecs[1]  = '{1'b1, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b0, 1'b1, 6'd1};
    vecs[2]  = '{1'b1, 1'b0, 32'h1001_0004, 32'h0,         32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1, 6'd1};
    vecs[3]  = '{1'b1, 1'b1, 32'h0040_0000, 32'h1111_2222, 32'h0,         1'b1, 1'b0, 1'b0, 6'd0};
    vecs[4]  = '{1'b1, 1'b0, 32'h1001_0100, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 6'd0};
    vecs[5]  = '{1'b1, 1'b0, 32'h1001_0002, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 6'd0};
    vecs[6]  = '{1'b1, 1'b0, 32'h1001_00FC, 32'h0,         32'h5000_003F, 1'b0, 1'b0, 1'b1, 6'd63};
    vecs[7]  = '{1'b0, 1'b0, 32'h0040_00FC, 32'h0,         32'hA000_003F, 1'b0, 1'b1, 1'b0, 6'd63};
    vecs[8]  = '{1'b0, 1'b0, 32'h003F_FFFC, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 6'd0};
    vecs[9]  = '{1'b0, 1'b0, 32'h0040_0100, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 6'd0};
    vecs[10] = '{1'b1, 1'b0, 32'h0040_0004, 32'h0,         32'hA000_0001, 1'b0, 1'b1, 1'b0, 6'd1};
    vecs[11] = '{1'b0, 1'b0, 32'h1001_0008, 32'h0,         32'h5000_0002, 1'b0, 1'b0, 1'b1, 6'd2};
    vecs[12] = '{1'b1, 1'b1, 32'h1001_00FC, 32'h0BAD_F00D, 32'h0,         1'b0, 1'b0, 1'b1, 6'd63};
    vecs[13] = '{1'b1, 1'b0, 32'h1001_00FC, 32'h0,         32'h0BAD_F00D, 1'b0, 1'b0, 1'b1, 6'd63};
    vecs[14] = '{1'b1, 1'b1, 32'h1001_0006, 32'h7777_7777, 32'h0,         1'b1, 1'b0, 1'b0, 6'd0};

    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset acks errs we", {if_ack, d_ack, if_err, d_err, ram_we}, 0);
    checkOutput("reset if_rdata", if_rdata, 0);
    checkOutput("reset d_rdata", d_rdata, 0);
    checkOutput("reset addrs", {rom_addr, ram_addr}, 0);
    checkOutput("reset ram_wdata", ram_wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) applyStimulus(vecs[i], $sformatf("v%0d", i));

    // Reset asserted during the ACCESS cycle of a store.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1001_0010; d_wdata = 32'h1234_5678;
    @(posedge clk); @(negedge clk);
    checkOutput("abort ram_we before", ram_we, 1);
    checkOutput("abort ram_addr", ram_addr, 4);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort ram_we", ram_we, 0);
    checkOutput("abort busy", busy, 0);
    d_req = 1'b0; d_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("abort no ack %0d", i), {if_ack, d_ack, busy}, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(vecs[0], "fresh if");
    fresh = '{1'b1, 1'b0, 32'h1001_0010, 32'h0, 32'h5000_0004, 1'b0, 1'b0, 1'b1, 6'd4};
    applyStimulus(fresh, "aborted store");

    // Clean reset, then both requesters held continuously.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0040_0008;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0008;
    n = 0; cycles = 0; lowrun = 0; maxlow = 0;
    while (n < 4 && cycles < 60) begin
      @(negedge clk);
      cycles++;
      if (!busy) lowrun++;
      else lowrun = 0;
      if (lowrun > maxlow) maxlow = lowrun;
      if (if_ack && n < 4) begin
        order[n] = 0;
        n++;
        checkOutput("contend if_rdata", if_rdata, 32'h2010_0005);
      end
      if (d_ack && n < 4) begin
        order[n] = 1;
        n++;
        checkOutput("contend d_rdata", d_rdata, 32'h5000_0002);
      end
      if (n == 4) begin
        if_req = 1'b0; d_req = 1'b0;
      end
    end
    if_req = 1'b0; d_req = 1'b0;
    checkOutput("contend ack count", n, 4);
    for (int i = 0; i < n; i++) checkOutput($sformatf("contend order %0d", i), order[i], i % 2);
    checkOutput("contend busy gap", (maxlow <= 1) ? 1 : 0, 1);
    repeat (2) @(negedge clk);
    checkOutput("contend quiet", {busy, if_ack, d_ack}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mu_mem_arbiter.md
Name: mu_mem_arbiter

Overview:
Memory-unit access controller for the multicycle MIPS core. It shares the 64x32 instruction ROM and the 64x32 data RAM between two requesters: instruction fetch (IF, read-only) and data load/store (D). The block decodes the byte address into ROM space, RAM space or error, and sequences one single-port access per grant. It returns read data or an error with a fixed latency.

Parameters:
DATA_WIDTH, 32, word width in bits
ADDR_WIDTH, 64, memory depth in words (ROM and RAM each)
IDX_W, 6, word-index width, log2(ADDR_WIDTH)
ROM_BASE, 32'h0040_0000, byte base address of ROM
RAM_BASE, 32'h1001_0000, byte base address of RAM

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held until if_ack
if_addr  in  32  fetch byte address
if_ack  out  1  one-cycle fetch response pulse
if_rdata  out  DATA_WIDTH  fetch read data, valid while if_ack=1
if_err  out  1  fetch error, valid while if_ack=1
d_req  in  1  data request; held until d_ack
d_we  in  1  1=store, 0=load
d_addr  in  32  data byte address
d_wdata  in  DATA_WIDTH  store data
d_ack  out  1  one-cycle data response pulse
d_rdata  out  DATA_WIDTH  load data, valid while d_ack=1
d_err  out  1  data error, valid while d_ack=1
rom_addr  out  IDX_W  ROM word index
rom_rdata  in  DATA_WIDTH  ROM synchronous read data, one-cycle latency
ram_addr  out  IDX_W  RAM word index
ram_we  out  1  RAM write strobe
ram_wdata  out  DATA_WIDTH  RAM write data
ram_rdata  in  DATA_WIDTH  RAM synchronous read data, one-cycle latency
busy  out  1  1 when state is not IDLE

Behaviour:
- Reset (rst_n=0, asynchronous) forces: state=IDLE, last_grant=D, all outputs 0 (acks, errs, rdata, rom_addr, ram_addr, ram_we, ram_wdata, busy).
- FSM: IDLE -> ACCESS -> WAIT -> RESP -> IDLE, one cycle per state after IDLE.
- IDLE: requests are sampled only in IDLE.
  - If any request is present, the block grants one requester.
  - On the grant edge it latches owner, address, we and wdata, decodes the address, and moves to ACCESS.
  - If no request is present, it stays in IDLE.
- Arbitration: with a single requester, that requester wins. With both requesting, the grant goes to the requester other than last_grant. last_grant updates on every grant. The first contended grant after reset goes to IF.
- Decode, for the latched byte address A:
  - A[1:0]!=0 gives a misaligned error.
  - ROM_BASE <= A < ROM_BASE+4*ADDR_WIDTH selects ROM.
  - RAM_BASE <= A < RAM_BASE+4*ADDR_WIDTH selects RAM.
  - Any other address gives an error.
  - A store to ROM gives an error.
  - Word index = (A - base)[IDX_W+1:2].
- ACCESS: rom_addr or ram_addr carries the latched index; the other address output holds its previous value. ram_we=1 for exactly this cycle, and only for a valid RAM store. ram_wdata = latched wdata.
- WAIT: memory data is now valid. The rdata register loads as follows:
  - valid load or fetch: the selected memory's data (rom_rdata or ram_rdata)
  - store or error: 0
  - The err flag is registered in the same cycle.
- RESP: the owner's ack=1 for one cycle, with the owner's rdata and err valid. The non-owner's ack stays 0. Next state is IDLE.
- Latency: request sampled at edge E0, ack high in the cycle following edge E3. The latency is the same for errors.
- Handshake: a requester drops req in the cycle after its ack. A req still high in IDLE is treated as a new request.
- Errored requests never touch memory: ram_we stays 0.
- rdata and err outputs read 0 whenever the matching ack=0.
- Reset asserted mid-transaction: the transaction is aborted, ram_we deasserts immediately, and no ack is issued.

Test Plan:
1. IF read 0x0040_0008, ROM word2=0x2010_0005 -> rom_addr=2 in ACCESS; if_ack 3 cycles after grant edge; if_rdata=0x2010_0005; if_err=0.
2. D store 0x1001_0004 with data 0xDEADBEEF, then D load 0x1001_0004 -> ram_we high exactly one cycle with ram_addr=1; load returns d_rdata=0xDEADBEEF, d_err=0.
3. if_req and d_req held continuously, each re-requesting the cycle after its ack -> grants alternate IF, D, IF, D; busy never low for more than 1 cycle between grants.
4. Errors -> each gives d_err=1 with d_ack at normal latency, ram_we never asserted, d_rdata=0:
   - D store to 0x0040_0000
   - D load 0x1001_0100 (word 64)
   - D load 0x1001_0002 (misaligned)
5. Boundaries: D load 0x1001_00FC -> ram_addr=63; IF read 0x0040_00FC -> rom_addr=63; 0x003F_FFFC -> if_err=1.
6. rst_n dropped during ACCESS of a store -> ram_we=0 immediately, busy=0, no acks; after release, a fresh IF request completes normally.
